frame_transmittion_select_param: RTL and testbench



---
 rtl/frame_transmittion_select_param.sv | 231 +++++++++++++++++++++++
 tb/tb_frame_transmittion_select_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_transmittion_select_param.sv
// frame_transmittion_select_param: delays host frames through a header line and forwards each frame as TSN or standard, or discards it.
// Latency: ETYPE_OFS+3 cycles from input beat to ov_data (ETYPE_OFS+2 delay entries plus the output register).
// Backpressure: none; a beat is accepted every cycle and input gaps pass through unchanged. Define FTS_DISCARD_CNT_EN to build ov_discard_cnt.
module frame_transmittion_select_param #(
  parameter int          DATA_W      = 9,
  parameter int          ETYPE_OFS   = 12,
  parameter logic [15:0] TSN_ETYPE   = 16'h1800,
  parameter logic [2:0]  ST_MAX_TYPE = 3'd2,
  parameter int          MAX_LEN     = 2047,
  parameter int          CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rc_rxenable,
  input  logic              i_st_rxenable,
  input  logic              i_hardware_initial_finish,
  input  logic [DATA_W-1:0] iv_data,
  input  logic              i_data_wr,
  output logic [DATA_W-1:0] ov_data,
  output logic              o_data_wr,
  output logic [15:0]       ov_eth_type,
  output logic              o_standardpkt_tsnpkt_flag,
  output logic              o_len_err,
  output logic [CNT_W-1:0]  ov_tsn_pkt_cnt,
  output logic [CNT_W-1:0]  ov_std_pkt_cnt,
  output logic [CNT_W-1:0]  ov_discard_cnt
);

  localparam int D     = ETYPE_OFS + 2;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int MRK   = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, TRAN, DISCARD} state_t;

  state_t            state;
  state_t            state_nxt;

  // Delay line: entry 0 is the oldest beat, entry D-1 the newest.
  logic [D-1:0]      dl_vld;
  logic [DATA_W-1:0] dl_dat [D];

  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [LEN_W-1:0]  cnt_inc;

  logic [DATA_W-1:0] data_nxt;
  logic              wr_nxt;
  logic [15:0]       etype_nxt;
  logic              flag_nxt;
  logic              len_err_nxt;
  logic              inc_tsn;
  logic              inc_std;

  logic              old_vld;
  logic [DATA_W-1:0] old_dat;
  logic [15:0]       etype;
  logic              frame_start;
  logic              hdr_bad;
  logic              is_tsn;
  logic              is_st;
  logic              fwd_ok;
  logic              fwd_flag;

  assign old_vld     = dl_vld[0];
  assign old_dat     = dl_dat[0];
  assign etype       = {dl_dat[D-2][7:0], dl_dat[D-1][7:0]};
  assign frame_start = old_vld && old_dat[MRK];
  assign is_tsn      = (etype == TSN_ETYPE);
  assign is_st       = (old_dat[7:5] <= ST_MAX_TYPE);
  assign cnt_inc     = beat_cnt + LEN_W'(1);

  // Shift the header delay line every cycle; idle input cycles enter as empty entries.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dl_vld <= '0;
      for (int i = 0; i < D; i++) dl_dat[i] <= '0;
    end else begin
      for (int i = 0; i < D-1; i++) begin
        dl_vld[i] <= dl_vld[i+1];
        dl_dat[i] <= dl_dat[i+1];
      end
      dl_vld[D-1] <= i_data_wr;
      dl_dat[D-1] <= i_data_wr ? iv_data : '0;
    end
  end

  // The whole header must be present and marker-free behind the first beat, otherwise the frame is a runt or has a gap.
  always_comb begin
    hdr_bad = 1'b0;
    for (int i = 1; i < D; i++) begin
      if (!dl_vld[i] || dl_dat[i][MRK]) hdr_bad = 1'b1;
    end
  end

  // Per-frame forwarding decision from the configuration stage and the EtherType.
  always_comb begin
    fwd_ok   = 1'b0;
    fwd_flag = 1'b0;
    if (!hdr_bad && i_hardware_initial_finish) begin
      case ({i_rc_rxenable, i_st_rxenable})
        2'b00: begin
          fwd_ok   = !is_tsn;
          fwd_flag = 1'b1;
        end
        2'b10: begin
          fwd_ok   = !(is_tsn && is_st);
          fwd_flag = !is_tsn;
        end
        2'b11: begin
          fwd_ok   = 1'b1;
          fwd_flag = !is_tsn;
        end
        default: begin
          fwd_ok   = 1'b0;
          fwd_flag = 1'b0;
        end
      endcase
    end
  end

`ifdef FTS_DISCARD_CNT_EN
  logic             inc_disc;
  logic [CNT_W-1:0] disc_cnt;
`endif

  // Next-state and next-output logic of the frame FSM.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = beat_cnt;
    data_nxt    = '0;
    wr_nxt      = 1'b0;
    etype_nxt   = ov_eth_type;
    flag_nxt    = o_standardpkt_tsnpkt_flag;
    len_err_nxt = 1'b0;
    inc_tsn     = 1'b0;
    inc_std     = 1'b0;
`ifdef FTS_DISCARD_CNT_EN
    inc_disc    = 1'b0;
`endif
    case (state)
      IDLE: begin
        etype_nxt = '0;
        flag_nxt  = 1'b0;
        cnt_nxt   = '0;
        if (frame_start) begin
          etype_nxt = etype;
          if (fwd_ok) begin
            data_nxt  = old_dat;
            wr_nxt    = 1'b1;
            flag_nxt  = fwd_flag;
            cnt_nxt   = LEN_W'(1);
            inc_std   = fwd_flag;
            inc_tsn   = !fwd_flag;
            state_nxt = TRAN;
          end else begin
            state_nxt = DISCARD;
`ifdef FTS_DISCARD_CNT_EN
            inc_disc  = 1'b1;
`endif
          end
        end
      end
      TRAN: begin
        data_nxt = old_dat;
        wr_nxt   = old_vld;
        if (old_vld) begin
          cnt_nxt = cnt_inc;
          if (old_dat[MRK]) begin
            state_nxt = IDLE;
          end else if (cnt_inc == LEN_W'(MAX_LEN)) begin
            // Close the frame early so downstream sees a well-formed end, then drop the rest.
            data_nxt[MRK] = 1'b1;
            len_err_nxt   = 1'b1;
            state_nxt     = DISCARD;
          end
        end
      end
      DISCARD: begin
        flag_nxt = 1'b0;
        if (old_vld && old_dat[MRK]) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, beat counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                     <= IDLE;
      beat_cnt                  <= '0;
      ov_data                   <= '0;
      o_data_wr                 <= 1'b0;
      ov_eth_type               <= '0;
      o_standardpkt_tsnpkt_flag <= 1'b0;
      o_len_err                 <= 1'b0;
    end else begin
      state                     <= state_nxt;
      beat_cnt                  <= cnt_nxt;
      ov_data                   <= data_nxt;
      o_data_wr                 <= wr_nxt;
      ov_eth_type               <= etype_nxt;
      o_standardpkt_tsnpkt_flag <= flag_nxt;
      o_len_err                 <= len_err_nxt;
    end
  end

  // Forwarded-frame statistics per class; they wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_tsn_pkt_cnt <= '0;
      ov_std_pkt_cnt <= '0;
    end else begin
      if (inc_tsn) ov_tsn_pkt_cnt <= ov_tsn_pkt_cnt + CNT_W'(1);
      if (inc_std) ov_std_pkt_cnt <= ov_std_pkt_cnt + CNT_W'(1);
    end
  end

`ifdef FTS_DISCARD_CNT_EN
  // Frames dropped at the decision point; truncated remainders are not counted.
  always_ff @(posedge i_clk) begin
    if (i_rst) disc_cnt <= '0;
    else if (inc_disc) disc_cnt <= disc_cnt + CNT_W'(1);
  end
  assign ov_discard_cnt = disc_cnt;
`else
  assign ov_discard_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_transmittion_select_param.sv
// Bench for frame_transmittion_select_param: table-driven per-frame config vectors plus hand-written sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Output beats are logged with their cycle stamp and compared against bench-computed frames.
module tb_frame_transmittion_select_param;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_rc_rxenable = 1'b0;
  logic        i_st_rxenable = 1'b0;
  logic        i_hardware_initial_finish = 1'b0;
  logic [8:0]  iv_data = '0;
  logic        i_data_wr = 1'b0;
  logic [8:0]  ov_data;
  logic        o_data_wr;
  logic [15:0] ov_eth_type;
  logic        o_standardpkt_tsnpkt_flag;
  logic        o_len_err;
  logic [31:0] ov_tsn_pkt_cnt;
  logic [31:0] ov_std_pkt_cnt;
  logic [31:0] ov_discard_cnt;

  always #5 clk = ~clk;

  frame_transmittion_select_param dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_rc_rxenable(i_rc_rxenable),
    .i_st_rxenable(i_st_rxenable),
    .i_hardware_initial_finish(i_hardware_initial_finish),
    .iv_data(iv_data),
    .i_data_wr(i_data_wr),
    .ov_data(ov_data),
    .o_data_wr(o_data_wr),
    .ov_eth_type(ov_eth_type),
    .o_standardpkt_tsnpkt_flag(o_standardpkt_tsnpkt_flag),
    .o_len_err(o_len_err),
    .ov_tsn_pkt_cnt(ov_tsn_pkt_cnt),
    .ov_std_pkt_cnt(ov_std_pkt_cnt),
    .ov_discard_cnt(ov_discard_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  dat;
    int          cyc;
    logic        flag;
    logic [15:0] et;
  } ob_t;

  ob_t out_q[$];
  int  len_err_cnt = 0;

  always @(negedge clk) begin
    if (o_data_wr) out_q.push_back('{ov_data, cyc, o_standardpkt_tsnpkt_flag, ov_eth_type});
    if (o_len_err) len_err_cnt++;
  end

  int n_run  = 0;
  int n_fail = 0;
  int exp_tsn = 0, exp_std = 0, exp_disc = 0;
  int first_in_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] beat(input int i, input int len, input logic [15:0] et, input logic [7:0] b0);
    logic [7:0] b;
    if (i == 0) b = b0;
    else if (i == 12) b = et[15:8];
    else if (i == 13) b = et[7:0];
    else b = 8'(i);
    return {(i == 0 || i == len - 1), b};
  endfunction

  task automatic drive_beat(input logic v, input logic [8:0] d);
    @(posedge clk);
    #1;
    i_data_wr = v;
    iv_data   = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive_beat(1'b0, 9'h000);
  endtask

  // rst_at >= 0 aborts the frame at that beat with a one-cycle reset.
  task automatic send_frame(input int len, input logic [15:0] et, input logic [7:0] b0,
                            input int gap_at, input int gap_len, input int rst_at);
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        @(posedge clk);
        #1;
        i_data_wr = 1'b0;
        iv_data   = '0;
        i_rst     = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        return;
      end
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) drive_beat(1'b0, 9'h000);
      end
      drive_beat(1'b1, beat(i, len, et, b0));
      if (i == 0) first_in_cyc = cyc;
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " tsn_cnt"}, 64'(ov_tsn_pkt_cnt), 64'(exp_tsn));
    chk({tag, " std_cnt"}, 64'(ov_std_pkt_cnt), 64'(exp_std));
`ifdef FTS_DISCARD_CNT_EN
    chk({tag, " discard_cnt"}, 64'(ov_discard_cnt), 64'(exp_disc));
`else
    chk({tag, " discard_cnt"}, 64'(ov_discard_cnt), 64'(0));
`endif
  endtask

  typedef struct {
    logic        rc;
    logic        st;
    logic        init;
    logic [15:0] et;
    logic [7:0]  b0;
    logic        fwd;
    logic        flag;
  } vec_t;

  vec_t vt[9];

  initial begin
    int base, nout, bad, mk, le0;

    vt[0] = '{1'b0, 1'b0, 1'b0, 16'h0800, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 16'h1800, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 16'h0800, 8'h00, 1'b1, 1'b1};
    vt[3] = '{1'b1, 1'b0, 1'b1, 16'h1800, 8'h40, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 16'h1800, 8'h60, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 16'h1800, 8'h40, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b1, 16'h0800, 8'h00, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b1, 16'h0800, 8'h20, 1'b1, 1'b1};
    vt[8] = '{1'b1, 1'b1, 1'b1, 16'h0806, 8'hE0, 1'b1, 1'b1};

    // Reset state
    idle(3);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("reset ov_data", 64'(ov_data), 64'(0));
    chk("reset o_data_wr", 64'(o_data_wr), 64'(0));
    chk("reset ov_eth_type", 64'(ov_eth_type), 64'(0));
    chk("reset flag", 64'(o_standardpkt_tsnpkt_flag), 64'(0));
    chk("reset len_err", 64'(o_len_err), 64'(0));
    chk_counters("reset");

    // Table-driven configuration vectors, one 64-beat frame each
    for (int k = 0; k < 9; k++) begin
      i_rc_rxenable             = vt[k].rc;
      i_st_rxenable             = vt[k].st;
      i_hardware_initial_finish = vt[k].init;
      base = out_q.size();
      send_frame(64, vt[k].et, vt[k].b0, -1, 0, -1);
      idle(24);
      if (!vt[k].fwd) exp_disc++;
      else if (vt[k].flag) exp_std++;
      else exp_tsn++;
      nout = out_q.size() - base;
      chk($sformatf("v%0d beats", k), 64'(nout), vt[k].fwd ? 64'(64) : 64'(0));
      if (vt[k].fwd && nout == 64) begin
        chk($sformatf("v%0d latency", k), 64'(out_q[base].cyc - first_in_cyc), 64'(15));
        chk($sformatf("v%0d first", k), 64'(out_q[base].dat), 64'({1'b1, vt[k].b0}));
        chk($sformatf("v%0d last marker", k), 64'(out_q[base+63].dat[8]), 64'(1));
        chk($sformatf("v%0d flag", k), 64'(out_q[base].flag), 64'(vt[k].flag));
        chk($sformatf("v%0d etype", k), 64'(out_q[base].et), 64'(vt[k].et));
      end
      chk_counters($sformatf("v%0d", k));
    end

    i_rc_rxenable = 1'b1;
    i_st_rxenable = 1'b1;
    i_hardware_initial_finish = 1'b1;

    // Runt followed back-to-back by a full frame
    base = out_q.size();
    send_frame(10, 16'h0800, 8'h11, -1, 0, -1);
    send_frame(64, 16'h0800, 8'h22, -1, 0, -1);
    idle(24);
    exp_disc++;
    exp_std++;
    nout = out_q.size() - base;
    chk("runt next beats", 64'(nout), 64'(64));
    if (nout == 64) begin
      bad = 0;
      for (int i = 0; i < 64; i++)
        if (out_q[base+i].dat !== beat(i, 64, 16'h0800, 8'h22)) bad++;
      chk("runt next intact", 64'(bad), 64'(0));
    end
    chk_counters("runt");

    // Over-length frame truncated at MAX_LEN, next frame back-to-back
    base = out_q.size();
    le0  = len_err_cnt;
    send_frame(3000, 16'h0800, 8'h33, -1, 0, -1);
    send_frame(64, 16'h0800, 8'h44, -1, 0, -1);
    idle(24);
    exp_std += 2;
    nout = out_q.size() - base;
    chk("ovl beats", 64'(nout), 64'(2047 + 64));
    chk("ovl len_err pulses", 64'(len_err_cnt - le0), 64'(1));
    if (nout == 2047 + 64) begin
      chk("ovl trunc beat", 64'(out_q[base+2046].dat), 64'({1'b1, 8'(2046)}));
      mk = 0;
      for (int i = 0; i < 2047; i++) if (out_q[base+i].dat[8]) mk++;
      chk("ovl markers", 64'(mk), 64'(2));
      chk("ovl next first", 64'(out_q[base+2047].dat), 64'({1'b1, 8'h44}));
      chk("ovl next last", 64'(out_q[base+2047+63].dat[8]), 64'(1));
    end
    chk_counters("ovl");

    // Three-cycle gap at beat 40 passes through
    base = out_q.size();
    send_frame(64, 16'h0800, 8'h55, 40, 3, -1);
    idle(24);
    exp_std++;
    nout = out_q.size() - base;
    chk("gap beats", 64'(nout), 64'(64));
    if (nout == 64) begin
      chk("gap pre", 64'(out_q[base+39].cyc - out_q[base].cyc), 64'(39));
      chk("gap span", 64'(out_q[base+40].cyc - out_q[base+39].cyc), 64'(4));
      chk("gap post", 64'(out_q[base+63].cyc - out_q[base+40].cyc), 64'(23));
    end

    // Reset at beat 20 of a forwarded frame
    send_frame(64, 16'h0800, 8'h66, -1, 0, 20);
    exp_tsn = 0;
    exp_std = 0;
    exp_disc = 0;
    @(negedge clk);
    chk("rst ov_data", 64'(ov_data), 64'(0));
    chk("rst o_data_wr", 64'(o_data_wr), 64'(0));
    chk("rst ov_eth_type", 64'(ov_eth_type), 64'(0));
    chk("rst flag", 64'(o_standardpkt_tsnpkt_flag), 64'(0));
    chk_counters("rst");
    base = out_q.size();
    idle(40);
    chk("rst no stale beats", 64'(out_q.size() - base), 64'(0));
    base = out_q.size();
    send_frame(64, 16'h1800, 8'h77, -1, 0, -1);
    idle(24);
    exp_tsn++;
    nout = out_q.size() - base;
    chk("post-rst beats", 64'(nout), 64'(64));
    if (nout == 64) chk("post-rst flag", 64'(out_q[base].flag), 64'(0));
    chk_counters("post-rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
